cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of FU result requesters.
REQ-002 Parameter NUM_CDB, default 2: number of CDB broadcast lanes; SHALL satisfy 1 <= NUM_CDB <= NUM_REQ.
REQ-003 Parameter PTR_W, default $clog2(NUM_REQ) (minimum 1): width of the round-robin pointer.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-006 flush  input  1  synchronous squash of lane contents (branch mispredict).
REQ-007 fu_valid  input  NUM_REQ  per-FU result-valid flags.
REQ-008 fu_ready  output  NUM_REQ  per-FU accept, combinational from current state and fu_valid.
REQ-009 fu_dst_addr  input  NUM_REQ x `PHYSICAL_REG_NUM_WIDTH  result destination physical registers.
REQ-010 fu_val  input  NUM_REQ x `REG_VAL_WIDTH  result values.
REQ-011 fu_tag  input  NUM_REQ x `ROB_SIZE_WIDTH  result ROB tags.
REQ-012 cdb_ready  input  1  all CDB consumers can accept this cycle.
REQ-013 cdb_valid  output  NUM_CDB  lane valid flags.
REQ-014 cdb_register_addr  output  NUM_CDB x `PHYSICAL_REG_NUM_WIDTH  lane destination registers.
REQ-015 cdb_register_val  output  NUM_CDB x `REG_VAL_WIDTH  lane values.
REQ-016 cdb_tag  output  NUM_CDB x `ROB_SIZE_WIDTH  lane ROB tags.
REQ-017 cdb_src_fu  output  NUM_CDB x PTR_W  index of the FU that owns each lane.

Function
REQ-018 Transfer: a result transfers on a cycle where fu_valid[i] and fu_ready[i] are both 1.
REQ-019 Output stage acceptance: the output stage accepts new results when cdb_ready = 1 or no cdb_valid bit is set. This condition is named "accept".
REQ-020 Ready gating: when accept = 0, every fu_ready bit SHALL be 0.
REQ-021 Grant selection: when accept = 1, fu_ready SHALL be 1 for the first min(NUM_CDB, popcount(fu_valid)) valid requesters.
  - Scan order is rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - All other fu_ready bits SHALL be 0.
REQ-022 Lane assignment: the k-th grant in scan order SHALL be loaded into lane k. Lanes numbered >= the grant count SHALL load cdb_valid = 0.
REQ-023 Latency: a result transferred in cycle N SHALL appear on the CDB in cycle N+1. Latency is exactly 1 cycle.
REQ-024 Hold: when cdb_ready = 0 and any cdb_valid bit is set, all cdb_* outputs SHALL hold their values unchanged.
REQ-025 Pointer update: when at least one grant occurs, rr_ptr SHALL become (index of last grant + 1) mod NUM_REQ. Otherwise rr_ptr SHALL hold.
REQ-026 Fairness: a requester holding fu_valid = 1 continuously SHALL be granted within ceil(NUM_REQ/NUM_CDB) cycles in which accept = 1.
REQ-027 Flush: when flush = 1, all cdb_valid bits SHALL clear at the next edge, and fu_ready SHALL be all 0 in that cycle.
  - rr_ptr SHALL hold.
  - Flush overrides hold and new grants.
REQ-028 Empty request set: when fu_valid = 0 and accept = 1, cdb_valid SHALL go to 0 at the next edge.
REQ-029 Saturation: when all NUM_REQ requesters are valid and NUM_CDB = NUM_REQ, all requesters SHALL be granted and rr_ptr SHALL be unchanged (wraps onto itself).
REQ-030 Contract: fu_dst_addr, fu_val and fu_tag SHALL be sampled only at a transfer. Behaviour when a requester drops fu_valid without a transfer is legal; the arbiter keeps no memory of it.

Reset
REQ-031 While reset = 0, outputs and state SHALL take these values asynchronously:
  - cdb_valid = 0, cdb_register_addr = 0, cdb_register_val = 0, cdb_tag = 0, cdb_src_fu = 0.
  - rr_ptr = 0.
  - fu_ready = 0.
REQ-032 Reset asserted mid-transfer SHALL discard that transfer; no partial lane SHALL appear after reset deasserts.
REQ-033 On the first edge after reset deasserts, arbitration SHALL start with rr_ptr = 0.

Structure
REQ-034 Shared package: NUM_OF_FU, NUM_OF_CDB, the width macros, and a cdb_entry_t struct (valid, addr, val, tag, src_fu) SHALL live in the shared defines/package.
REQ-035 Sub-module: the round-robin multi-grant picker SHALL be a separate combinational sub-module, rr_multi_picker.
  - Inputs: requests, pointer.
  - Outputs: grant vector and per-lane index.
REQ-036 Top-level contents: the output lane registers and rr_ptr register live in the top module.
REQ-037 Interface bundling: the CDB outputs SHALL be connectable to the existing CDB_IF master side.

Verification
REQ-038 Default parameters, rr_ptr = 0, fu_valid = 4'b1111, cdb_ready = 1 -> fu_ready = 4'b0011 and rr_ptr = 2. Next cycle: lanes carry FU0 and FU1 with cdb_src_fu = {0,1}, and fu_ready = 4'b1100.
REQ-039 Lanes valid, cdb_ready = 0 for 3 cycles, fu_valid = 4'b0100 -> fu_ready = 0 and lane outputs stable for 3 cycles. FU2 is granted on the cycle cdb_ready returns to 1.
REQ-040 rr_ptr = 3, fu_valid = 4'b1001 -> grant order FU3 then FU0: lane0 = FU3, lane1 = FU0, rr_ptr = 1.
REQ-041 flush = 1 with both lanes valid and fu_valid = 4'b0010 -> fu_ready = 0, cdb_valid = 0 next cycle, rr_ptr unchanged.
REQ-042 reset driven to 0 asynchronously mid-cycle with lanes valid -> cdb_valid = 0 immediately. After release, first grant with fu_valid = 4'b1000 puts FU3 in lane0 and sets rr_ptr = 0.
REQ-043 Random fu_valid for 10k cycles with random cdb_ready -> scoreboard finds no lost or duplicated result, and no requester waits longer than the REQ-026 bound.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: machine widths, default FU/lane counts, the lane
// record broadcast on the common data bus, and a small index helper.
package cdb_arbiter_pkg;

    localparam int NUM_OF_FU              = 4;
    localparam int NUM_OF_CDB             = 2;
    localparam int PHYSICAL_REG_NUM_WIDTH = 6;
    localparam int REG_VAL_WIDTH          = 32;
    localparam int ROB_SIZE_WIDTH         = 5;
    localparam int FU_IDX_W               = (NUM_OF_FU > 1) ? $clog2(NUM_OF_FU) : 1;

    // One CDB lane as seen by the CDB_IF consumers.
    typedef struct packed {
        logic                              valid;
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] addr;
        logic [REG_VAL_WIDTH-1:0]          val;
        logic [ROB_SIZE_WIDTH-1:0]         tag;
        logic [FU_IDX_W-1:0]               src_fu;
    } cdb_entry_t;

    // Single-step modulo for indices known to be below 2*n.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_picker.sv
// Round-robin multi-grant picker: scans requesters starting at the pointer
// and hands out up to NUM_CDB grants, reporting which requester lands in
// each lane and where the pointer should move afterwards.
module rr_multi_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = 2,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [PTR_W-1:0]              ptr,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_CDB-1:0]            lane_vld,
    output logic [NUM_CDB-1:0][PTR_W-1:0] lane_idx,
    output logic                          any_grant,
    output logic [PTR_W-1:0]              next_ptr
);

    // Scan in priority order; the k-th winner is steered into lane k.
    always_comb begin
        int cnt;
        int idx;
        int last;
        grant     = '0;
        lane_vld  = '0;
        lane_idx  = '0;
        next_ptr  = ptr;
        any_grant = 1'b0;
        cnt       = 0;
        idx       = 0;
        last      = 0;
        for (int s = 0; s < NUM_REQ; s++) begin
            idx = wrap_idx(int'(ptr) + s, NUM_REQ);
            if (req[idx] && (cnt < NUM_CDB)) begin
                grant[idx]    = 1'b1;
                lane_vld[cnt] = 1'b1;
                lane_idx[cnt] = PTR_W'(idx);
                last          = idx;
                cnt           = cnt + 1;
            end
        end
        if (cnt != 0) begin
            any_grant = 1'b1;
            // With every requester granted this wraps back onto ptr itself.
            next_ptr  = PTR_W'(wrap_idx(last + 1, NUM_REQ));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: collects results from NUM_REQ functional units and broadcasts
// up to NUM_CDB of them per cycle on registered CDB lanes, round-robin fair.
// The cdb_* port group lines up with the CDB_IF master side one-to-one.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_OF_FU,
    parameter int NUM_CDB = NUM_OF_CDB,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              flush,
    input  logic [NUM_REQ-1:0]                                fu_valid,
    output logic [NUM_REQ-1:0]                                fu_ready,
    input  logic [NUM_REQ-1:0][PHYSICAL_REG_NUM_WIDTH-1:0]    fu_dst_addr,
    input  logic [NUM_REQ-1:0][REG_VAL_WIDTH-1:0]             fu_val,
    input  logic [NUM_REQ-1:0][ROB_SIZE_WIDTH-1:0]            fu_tag,
    input  logic                                              cdb_ready,
    output logic [NUM_CDB-1:0]                                cdb_valid,
    output logic [NUM_CDB-1:0][PHYSICAL_REG_NUM_WIDTH-1:0]    cdb_register_addr,
    output logic [NUM_CDB-1:0][REG_VAL_WIDTH-1:0]             cdb_register_val,
    output logic [NUM_CDB-1:0][ROB_SIZE_WIDTH-1:0]            cdb_tag,
    output logic [NUM_CDB-1:0][PTR_W-1:0]                     cdb_src_fu
);

    cdb_entry_t                  lanes_p1 [NUM_CDB];
    logic [PTR_W-1:0]            rr_ptr;
    logic                        lanes_busy;
    logic                        accept;
    logic                        load;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_CDB-1:0]          lane_vld;
    logic [NUM_CDB-1:0][PTR_W-1:0] lane_idx;
    logic                        any_grant;
    logic [PTR_W-1:0]            next_ptr;

    rr_multi_picker #(
        .NUM_REQ (NUM_REQ),
        .NUM_CDB (NUM_CDB),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req       (fu_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .lane_vld  (lane_vld),
        .lane_idx  (lane_idx),
        .any_grant (any_grant),
        .next_ptr  (next_ptr)
    );

    // Output stage can take a new batch when drained downstream or empty;
    // flush and reset both suppress any handshake this cycle.
    always_comb begin
        lanes_busy = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            lanes_busy = lanes_busy | lanes_p1[k].valid;
        end
        accept   = cdb_ready || !lanes_busy;
        load     = accept && !flush;
        fu_ready = (reset && load) ? grant : '0;
    end

    // Stage p0 -> p1: lane registers and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                lanes_p1[k] <= '0;
            end
            rr_ptr <= '0;
        end else if (flush) begin
            // Squash only; the pointer keeps its fairness history.
            for (int k = 0; k < NUM_CDB; k++) begin
                lanes_p1[k].valid <= 1'b0;
            end
        end else if (accept) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                lanes_p1[k].valid <= lane_vld[k];
                if (lane_vld[k]) begin
                    lanes_p1[k].addr   <= fu_dst_addr[lane_idx[k]];
                    lanes_p1[k].val    <= fu_val[lane_idx[k]];
                    lanes_p1[k].tag    <= fu_tag[lane_idx[k]];
                    // The lane record's FU index is sized for the package FU count.
                    lanes_p1[k].src_fu <= FU_IDX_W'(lane_idx[k]);
                end
            end
            if (any_grant) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Flatten the lane records onto the CDB port bundle.
    always_comb begin
        cdb_valid         = '0;
        cdb_register_addr = '0;
        cdb_register_val  = '0;
        cdb_tag           = '0;
        cdb_src_fu        = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_valid[k]         = lanes_p1[k].valid;
            cdb_register_addr[k] = lanes_p1[k].addr;
            cdb_register_val[k]  = lanes_p1[k].val;
            cdb_tag[k]           = lanes_p1[k].tag;
            cdb_src_fu[k]        = PTR_W'(lanes_p1[k].src_fu);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: constant vector table for the directed behaviour,
// hand-written reset and saturation sequences, then a randomised run against
// an arbitration model and a result scoreboard.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int NC = 2;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic cdb_ready = 1'b0;
    logic [NR-1:0] fu_valid = '0;
    logic [NR-1:0] fu_ready;
    logic [NR-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] fu_dst_addr;
    logic [NR-1:0][REG_VAL_WIDTH-1:0]          fu_val;
    logic [NR-1:0][ROB_SIZE_WIDTH-1:0]         fu_tag;
    logic [NC-1:0]                             cdb_valid;
    logic [NC-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] cdb_register_addr;
    logic [NC-1:0][REG_VAL_WIDTH-1:0]          cdb_register_val;
    logic [NC-1:0][ROB_SIZE_WIDTH-1:0]         cdb_tag;
    logic [NC-1:0][PW-1:0]                     cdb_src_fu;

    logic sat_cdb_ready = 1'b0;
    logic [NR-1:0] sat_fu_valid = '0;
    logic [NR-1:0] sat_fu_ready;
    logic [NR-1:0]                             sat_cdb_valid;
    logic [NR-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] sat_cdb_register_addr;
    logic [NR-1:0][REG_VAL_WIDTH-1:0]          sat_cdb_register_val;
    logic [NR-1:0][ROB_SIZE_WIDTH-1:0]         sat_cdb_tag;
    logic [NR-1:0][PW-1:0]                     sat_cdb_src_fu;

    cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC), .PTR_W(PW)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .fu_valid          (fu_valid),
        .fu_ready          (fu_ready),
        .fu_dst_addr       (fu_dst_addr),
        .fu_val            (fu_val),
        .fu_tag            (fu_tag),
        .cdb_ready         (cdb_ready),
        .cdb_valid         (cdb_valid),
        .cdb_register_addr (cdb_register_addr),
        .cdb_register_val  (cdb_register_val),
        .cdb_tag           (cdb_tag),
        .cdb_src_fu        (cdb_src_fu)
    );

    cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NR), .PTR_W(PW)) dut_sat (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .fu_valid          (sat_fu_valid),
        .fu_ready          (sat_fu_ready),
        .fu_dst_addr       (fu_dst_addr),
        .fu_val            (fu_val),
        .fu_tag            (fu_tag),
        .cdb_ready         (sat_cdb_ready),
        .cdb_valid         (sat_cdb_valid),
        .cdb_register_addr (sat_cdb_register_addr),
        .cdb_register_val  (sat_cdb_register_val),
        .cdb_tag           (sat_cdb_tag),
        .cdb_src_fu        (sat_cdb_src_fu)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PHYSICAL_REG_NUM_WIDTH-1:0] exp_addr(input int i);
        return PHYSICAL_REG_NUM_WIDTH'(8 + i);
    endfunction
    function automatic logic [REG_VAL_WIDTH-1:0] exp_val(input int i);
        return 32'hC0DE_0000 | REG_VAL_WIDTH'(i);
    endfunction
    function automatic logic [ROB_SIZE_WIDTH-1:0] exp_tag(input int i);
        return ROB_SIZE_WIDTH'(16 + i);
    endfunction

    task automatic set_fixed_payload();
        for (int i = 0; i < NR; i++) begin
            fu_dst_addr[i] = exp_addr(i);
            fu_val[i]      = exp_val(i);
            fu_tag[i]      = exp_tag(i);
        end
    endtask

    task automatic check_lane(input string name, input int k, input int src);
        check({name, " src"},  64'(cdb_src_fu[k]),        64'(src));
        check({name, " addr"}, 64'(cdb_register_addr[k]), 64'(exp_addr(src)));
        check({name, " val"},  64'(cdb_register_val[k]),  64'(exp_val(src)));
        check({name, " tag"},  64'(cdb_tag[k]),           64'(exp_tag(src)));
    endtask

    // Reference arbitration: walk NR slots from ptr, first NC valid win.
    function automatic logic [NR-1:0] model_pick(input logic [NR-1:0] fv, input int ptr);
        logic [NR-1:0] g;
        int n;
        int i;
        g = '0;
        n = 0;
        i = ptr;
        repeat (NR) begin
            if (fv[i] && n < NC) begin
                g[i] = 1'b1;
                n++;
            end
            i = (i + 1) % NR;
        end
        return g;
    endfunction

    typedef struct {
        logic [NR-1:0] fv;
        logic          cr;
        logic          fl;
        logic [NR-1:0] ready;
        logic [NC-1:0] vld;
        int            src0;
        int            src1;
    } vec_t;

    typedef struct {
        int                                src;
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] addr;
        logic [REG_VAL_WIDTH-1:0]          val;
        logic [ROB_SIZE_WIDTH-1:0]         tag;
    } sb_t;

    vec_t tbl [14];
    sb_t  q [$];

    int            m_ptr;
    int            wait_cnt [NR];
    int            seq_no [NR];
    int            ix;
    int            last;
    logic          acc;
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] gr;
    sb_t           e;

    initial begin
        // fv, cdb_ready, flush, fu_ready, cdb_valid next, lane0 src, lane1 src
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0011, 2'b11, 0, 1};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b1100, 2'b11, 2, 3};
        tbl[2]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'b11, 2, 3};
        tbl[3]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'b11, 2, 3};
        tbl[4]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'b11, 2, 3};
        tbl[5]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 2'b01, 2, 0};
        tbl[6]  = '{4'b1001, 1'b1, 1'b0, 4'b1001, 2'b11, 3, 0};
        tbl[7]  = '{4'b0010, 1'b1, 1'b1, 4'b0000, 2'b00, 0, 0};
        tbl[8]  = '{4'b0011, 1'b0, 1'b0, 4'b0011, 2'b11, 1, 0};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'b11, 1, 0};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'b00, 0, 0};
        tbl[11] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 2'b01, 0, 0};
        tbl[12] = '{4'b1111, 1'b1, 1'b0, 4'b0110, 2'b11, 1, 2};
        tbl[13] = '{4'b1111, 1'b1, 1'b0, 4'b1001, 2'b11, 3, 0};

        // Reset values, with requests already present.
        set_fixed_payload();
        fu_valid  = '1;
        cdb_ready = 1'b1;
        #2;
        check("rst cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst fu_ready",  64'(fu_ready),  64'd0);
        check("rst addr",      64'(cdb_register_addr), 64'd0);
        check("rst val",       64'(cdb_register_val),  64'd0);
        check("rst tag",       64'(cdb_tag),           64'd0);
        check("rst src",       64'(cdb_src_fu),        64'd0);
        @(negedge clk);
        reset    = 1'b1;
        fu_valid = '0;

        for (int v = 0; v < 14; v++) begin
            fu_valid  = tbl[v].fv;
            cdb_ready = tbl[v].cr;
            flush     = tbl[v].fl;
            #1;
            check($sformatf("vec%0d fu_ready", v), 64'(fu_ready), 64'(tbl[v].ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d cdb_valid", v), 64'(cdb_valid), 64'(tbl[v].vld));
            if (tbl[v].vld[0]) check_lane($sformatf("vec%0d lane0", v), 0, tbl[v].src0);
            if (tbl[v].vld[1]) check_lane($sformatf("vec%0d lane1", v), 1, tbl[v].src1);
            @(negedge clk);
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of a pending transfer.
        fu_valid  = 4'b1111;
        cdb_ready = 1'b1;
        @(posedge clk);
        #2;
        check("arst pre lanes", 64'(cdb_valid), 64'b11);
        reset = 1'b0;
        #1;
        check("arst cdb_valid", 64'(cdb_valid), 64'd0);
        check("arst fu_ready",  64'(fu_ready),  64'd0);
        check("arst val",       64'(cdb_register_val), 64'd0);
        check("arst src",       64'(cdb_src_fu),       64'd0);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        fu_valid = '0;
        #1;
        check("post rst fu_ready", 64'(fu_ready), 64'd0);
        @(posedge clk);
        #1;
        check("post rst no lane", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        fu_valid = 4'b1000;
        #1;
        check("post rst grant", 64'(fu_ready), 64'b1000);
        @(posedge clk);
        #1;
        check("post rst cdb_valid", 64'(cdb_valid), 64'b01);
        check_lane("post rst lane0", 0, 3);
        @(negedge clk);
        fu_valid = 4'b1001;
        #1;
        check("post rst wrap grant", 64'(fu_ready), 64'b1001);
        @(posedge clk);
        #1;
        check_lane("post rst wrap lane0", 0, 0);
        check_lane("post rst wrap lane1", 1, 3);
        @(negedge clk);
        fu_valid = '0;

        // Saturation on the four-lane instance: pointer must wrap onto itself.
        sat_cdb_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            sat_fu_valid = 4'b1111;
            #1;
            check($sformatf("sat%0d fu_ready", r), 64'(sat_fu_ready), 64'hF);
            @(posedge clk);
            #1;
            check($sformatf("sat%0d cdb_valid", r), 64'(sat_cdb_valid), 64'hF);
            for (int k = 0; k < NR; k++) begin
                check($sformatf("sat%0d lane%0d src", r, k), 64'(sat_cdb_src_fu[k]), 64'(k));
                check($sformatf("sat%0d lane%0d val", r, k), 64'(sat_cdb_register_val[k]), 64'(exp_val(k)));
            end
            @(negedge clk);
        end
        sat_fu_valid  = '0;
        sat_cdb_ready = 1'b0;

        // Randomised traffic against the model and scoreboard.
        reset     = 1'b0;
        fu_valid  = '0;
        cdb_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 0;
        q.delete();
        for (int i = 0; i < NR; i++) begin
            wait_cnt[i] = 0;
            seq_no[i]   = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!fu_valid[i] && $urandom_range(1, 0) == 1) begin
                    fu_valid[i]    = 1'b1;
                    fu_dst_addr[i] = PHYSICAL_REG_NUM_WIDTH'($urandom);
                    fu_val[i]      = {8'(i), 24'(seq_no[i])};
                    fu_tag[i]      = ROB_SIZE_WIDTH'($urandom);
                    seq_no[i]++;
                    wait_cnt[i]    = 0;
                end
            end
            cdb_ready = ($urandom_range(3, 0) != 0);
            #1;
            acc     = cdb_ready || (cdb_valid == '0);
            exp_rdy = acc ? model_pick(fu_valid, m_ptr) : '0;
            check("rnd fu_ready", 64'(fu_ready), 64'(exp_rdy));
            if (cdb_ready) begin
                check("rnd lanes vs pending", 64'($countones(cdb_valid)), 64'(q.size()));
                for (int k = 0; k < NC; k++) begin
                    if (cdb_valid[k] && q.size() != 0) begin
                        e = q.pop_front();
                        check("rnd src",  64'(cdb_src_fu[k]),        64'(e.src));
                        check("rnd addr", 64'(cdb_register_addr[k]), 64'(e.addr));
                        check("rnd val",  64'(cdb_register_val[k]),  64'(e.val));
                        check("rnd tag",  64'(cdb_tag[k]),           64'(e.tag));
                    end
                end
                q.delete();
            end
            gr   = fu_valid & fu_ready;
            ix   = m_ptr;
            last = m_ptr;
            repeat (NR) begin
                if (gr[ix]) q.push_back('{ix, fu_dst_addr[ix], fu_val[ix], fu_tag[ix]});
                if (exp_rdy[ix]) last = ix;
                ix = (ix + 1) % NR;
            end
            if (exp_rdy != '0) m_ptr = (last + 1) % NR;
            for (int i = 0; i < NR; i++) begin
                if (fu_valid[i]) begin
                    if (acc) wait_cnt[i]++;
                    if (gr[i]) check($sformatf("rnd wait fu%0d over bound", i), 64'(wait_cnt[i] > 2), 64'd0);
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (gr[i]) fu_valid[i] = 1'b0;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
